sync_filter_bank: RTL and testbench

- Multi-channel clock-domain-crossing synchronizer; generalises the two-flop synchronizer to WIDTH independent channels with STAGES flops each.
- Adds a per-channel stability (debounce) filter, single-cycle rise/fall pulses and a saturating transition counter.
- Sits at the chip boundary between asynchronous pins (buttons, external status lines) and synchronous control logic.

---
 rtl/sync_filter_bank.sv | 148 ++++++++++++++
 tb/tb_sync_filter_bank.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sync_filter_bank.sv
`default_nettype none
// ============================================================================
// Module   : sync_filter_bank
// Brief    : WIDTH-channel STAGES-flop synchronizer with optional stability
//            filter (macro SYNC_FILTER_EN), rise/fall pulses and a saturating
//            transition counter.
// Revision : 1.0 - initial release
// ============================================================================
module sync_filter_bank #(
    parameter int               WIDTH         = 4,
    parameter int               STAGES        = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   async_in,
    input  logic               evt_clr,
    output logic [WIDTH-1:0]   sync_out,
    output logic [WIDTH-1:0]   rise,
    output logic [WIDTH-1:0]   fall,
    output logic [COUNT_W-1:0] evt_count
);

    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = COUNT_W + POP_W;
    localparam logic [SUM_W-1:0] EVT_MAX = SUM_W'({COUNT_W{1'b1}});

    if (WIDTH < 1 || STAGES < 2 || FILTER_CYCLES < 1) begin : g_param_check
        $error("sync_filter_bank: requires WIDTH>=1, STAGES>=2, FILTER_CYCLES>=1");
    end

    logic [WIDTH-1:0] chain_q [STAGES];
    logic [WIDTH-1:0] chain_d [STAGES];
    logic [WIDTH-1:0] synced_w;
    logic [WIDTH-1:0] sync_out_w;
    logic [WIDTH-1:0] sync_dly_q;
    logic [WIDTH-1:0] sync_dly_d;
    logic [WIDTH-1:0] edge_w;
    logic [POP_W-1:0] evt_pop_w;
    logic [SUM_W-1:0] evt_sum_w;
    logic [COUNT_W-1:0] evt_count_q;
    logic [COUNT_W-1:0] evt_count_d;

    // Plain shift chain: nothing may sit between metastability stages.
    always_comb begin
        chain_d[0] = async_in;
        for (int k = 1; k < STAGES; k++) begin
            chain_d[k] = chain_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                chain_q[k] <= RESET_VAL;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                chain_q[k] <= chain_d[k];
            end
        end
    end

    assign synced_w = chain_q[STAGES-1];

`ifdef SYNC_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] sync_out_q;
    logic [WIDTH-1:0] sync_out_d;

    // A channel only follows the synced value once it has differed from the
    // current output for FILTER_CYCLES consecutive edges.
    always_comb begin
        sync_out_d = sync_out_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (synced_w[i] == sync_out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                sync_out_d[i] = synced_w[i];
                cnt_d[i]      = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_out_q <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_out_q <= sync_out_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sync_out_w = sync_out_q;
`else
    assign sync_out_w = synced_w;
`endif

    assign sync_dly_d = sync_out_w;
    assign rise       = sync_out_w & ~sync_dly_q;
    assign fall       = ~sync_out_w & sync_dly_q;
    assign edge_w     = rise | fall;

    // Sum is widened so several simultaneous edges cannot wrap past the limit.
    always_comb begin
        evt_pop_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            evt_pop_w = evt_pop_w + POP_W'(edge_w[i]);
        end
        evt_sum_w = SUM_W'(evt_count_q) + SUM_W'(evt_pop_w);
        if (evt_clr) begin
            evt_count_d = '0;
        end else if (evt_sum_w > EVT_MAX) begin
            evt_count_d = '1;
        end else begin
            evt_count_d = evt_sum_w[COUNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_dly_q  <= RESET_VAL;
            evt_count_q <= '0;
        end else begin
            sync_dly_q  <= sync_dly_d;
            evt_count_q <= evt_count_d;
        end
    end

    assign sync_out  = sync_out_w;
    assign evt_count = evt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_filter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_filter_bank
// Brief    : Directed self-checking bench for sync_filter_bank, main instance
//            with defaults plus a STAGES=3 / COUNT_W=2 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_filter_bank;

`ifdef SYNC_FILTER_EN
    localparam int FLT = 4;
`else
    localparam int FLT = 0;
`endif
    localparam int LAT  = 2 + FLT;
    localparam int LAT2 = 3 + FLT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] async_in, async_in2;
    logic       evt_clr, evt_clr2;
    logic [3:0] sync_out, rise, fall, sync_out2, rise2, fall2;
    logic [7:0] evt_count;
    logic [1:0] evt_count2;

    int n_checks = 0;
    int n_errors = 0;
    logic seen_rise, seen_fall;

    always #5 clk = ~clk;

    sync_filter_bank #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(4),
                       .RESET_VAL(4'h0), .COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .evt_clr(evt_clr),
        .sync_out(sync_out), .rise(rise), .fall(fall), .evt_count(evt_count));

    sync_filter_bank #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(4),
                       .RESET_VAL(4'h0), .COUNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .async_in(async_in2), .evt_clr(evt_clr2),
        .sync_out(sync_out2), .rise(rise2), .fall(fall2), .evt_count(evt_count2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Tick while recording whether channel ch pulsed rise or fall.
    task automatic observe(input int n, input int ch);
        for (int t = 0; t < n; t++) begin
            tick(1);
            if (rise[ch]) seen_rise = 1'b1;
            if (fall[ch]) seen_fall = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; async_in = 4'hF; async_in2 = 4'h0;
        evt_clr = 1'b0; evt_clr2 = 1'b0;
        tick(3);
        check("rst_sync_out", 32'(sync_out), 32'h0);
        check("rst_rise_fall", 32'(rise | fall), 32'h0);
        check("rst_evt", 32'(evt_count), 32'h0);

        // Reset release with all inputs already high
        rst_n = 1'b1;
        tick(LAT - 1);
        check("rel_hold_out", 32'(sync_out), 32'h0);
        check("rel_hold_rise", 32'(rise), 32'h0);
        tick(1);
        check("rel_out", 32'(sync_out), 32'hF);
        check("rel_rise", 32'(rise), 32'hF);
        tick(1);
        check("rel_rise_end", 32'(rise), 32'h0);
        check("rel_evt", 32'(evt_count), 32'd4);

        async_in = 4'h0;
        tick(LAT + 2);
        check("all_low_out", 32'(sync_out), 32'h0);
        check("all_low_evt", 32'(evt_count), 32'd8);

        // Latency of a single channel step
        async_in = 4'h1;
        tick(LAT - 1);
        check("lat_before", 32'(sync_out), 32'h0);
        tick(1);
        check("lat_out", 32'(sync_out), 32'h1);
        check("lat_rise", 32'(rise), 32'h1);
        tick(1);
        check("lat_rise_end", 32'(rise), 32'h0);
        check("lat_evt", 32'(evt_count), 32'd9);

        // Three-cycle pulse on channel 1
        seen_rise = 1'b0; seen_fall = 1'b0;
        async_in = 4'h3;
        observe(3, 1);
        async_in = 4'h1;
        observe(10, 1);
        check("glitch3_out", 32'(sync_out), 32'h1);
        check("glitch3_rise", 32'(seen_rise), (FLT > 0) ? 32'd0 : 32'd1);
        check("glitch3_fall", 32'(seen_fall), (FLT > 0) ? 32'd0 : 32'd1);
        check("glitch3_evt", 32'(evt_count), (FLT > 0) ? 32'd9 : 32'd11);

        // Four-cycle pulse on channel 1 passes either build
        seen_rise = 1'b0; seen_fall = 1'b0;
        async_in = 4'h3;
        observe(4, 1);
        async_in = 4'h1;
        observe(12, 1);
        check("pulse4_rise", 32'(seen_rise), 32'd1);
        check("pulse4_fall", 32'(seen_fall), 32'd1);
        check("pulse4_evt", 32'(evt_count), (FLT > 0) ? 32'd11 : 32'd13);

        // Asynchronous reset mid-filter, channel 2 counter partway up
        async_in = 4'h5;
        tick(4);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out", 32'(sync_out), 32'h0);
        check("arst_pulses", 32'(rise | fall), 32'h0);
        check("arst_evt", 32'(evt_count), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(LAT - 1);
        check("arst_relat_before", 32'(sync_out), 32'h0);
        tick(1);
        check("arst_relat_out", 32'(sync_out), 32'h5);
        check("arst_relat_rise", 32'(rise), 32'h5);

        // Second instance: STAGES=3 latency on channel 3
        async_in2 = 4'h8;
        tick(LAT2 - 1);
        check("d2_lat_before", 32'(sync_out2), 32'h0);
        tick(1);
        check("d2_lat_out", 32'(sync_out2), 32'h8);
        check("d2_lat_rise", 32'(rise2), 32'h8);
        tick(1);
        check("d2_evt1", 32'(evt_count2), 32'd1);

        // Saturation at 3 with five clean toggles of channel 2
        for (int k = 1; k <= 5; k++) begin
            async_in2[2] = ~async_in2[2];
            tick(LAT2 + 2);
            if (k == 2) check("d2_sat_reach", 32'(evt_count2), 32'd3);
        end
        check("d2_sat_hold", 32'(evt_count2), 32'd3);
        check("d2_sat_out", 32'(sync_out2), 32'hC);

        // Clear coincident with a rise event drops that event
        async_in2[1] = 1'b1;
        tick(LAT2);
        check("d2_clr_rise", 32'(rise2), 32'h2);
        evt_clr2 = 1'b1;
        tick(1);
        check("d2_clr_evt", 32'(evt_count2), 32'd0);
        evt_clr2 = 1'b0;
        tick(1);
        check("d2_clr_dropped", 32'(evt_count2), 32'd0);

`ifndef SYNC_FILTER_EN
        // Unfiltered: a one-cycle input pulse gives rise then fall
        async_in2[0] = 1'b1;
        tick(1);
        async_in2[0] = 1'b0;
        tick(2);
        check("nf_pulse_rise", 32'(rise2), 32'h1);
        tick(1);
        check("nf_pulse_fall", 32'(fall2), 32'h1);
        check("nf_pulse_rise_end", 32'(rise2), 32'h0);
        tick(1);
        check("nf_pulse_fall_end", 32'(fall2), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
